// File: rtl/vga_text_ctrl.sv
// VGA text-mode controller: timing counters, char-buffer scan, font fetch, 3-cycle pixel pipeline.
// Optional blinking underline cursor when VGA_CURSOR_EN is defined.
module vga_text_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned COLS     = H_ACTIVE / 8,
  parameter int unsigned ROWS     = V_ACTIVE / 16,
  parameter int unsigned AW       = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [13:0]   wr_data,
  output logic [11:0]   font_addr,
  input  logic [7:0]    font_data,
  input  logic [7:0]    cursor_col,
  input  logic [7:0]    cursor_row,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          vga_r,
  output logic          vga_g,
  output logic          vga_b,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned CELLS   = COLS * ROWS;
  localparam int unsigned IW      = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [10:0] HMax    = 11'(H_TOTAL - 1);
  localparam logic [10:0] VMax    = 11'(V_TOTAL - 1);

  typedef struct packed {
    logic       act;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [2:0] hlo;
  } ctl_t;

  logic [10:0]   h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  ctl_t          s1_d, s1_q, s2_q;
  logic [IW-1:0] cell_0;
  logic [13:0]   char_mem [CELLS];
  logic [13:0]   char_d, char_q;
  logic [3:0]    vrow_d, vrow_q;
  logic [5:0]    attr_q;
  logic          pix_bit;
  logic          hsync_d, hsync_q, vsync_d, vsync_q, de_d, de_q, fs_d, fs_q;
  logic [2:0]    rgb_d, rgb_q;

  // Stage 0: raster counters and per-pixel control decode
  always_comb begin
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HMax) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VMax) ? '0 : v_cnt_q + 11'd1;
    end
  end

  always_comb begin
    s1_d.act = (h_cnt_q < 11'(H_ACTIVE)) && (v_cnt_q < 11'(V_ACTIVE));
    s1_d.hs  = (h_cnt_q >= 11'(H_ACTIVE + H_FP)) && (h_cnt_q < 11'(H_ACTIVE + H_FP + H_SYNC));
    s1_d.vs  = (v_cnt_q >= 11'(V_ACTIVE + V_FP)) && (v_cnt_q < 11'(V_ACTIVE + V_FP + V_SYNC));
    s1_d.fs  = (h_cnt_q == '0) && (v_cnt_q == '0);
    s1_d.hlo = h_cnt_q[2:0];
    cell_0   = IW'((32'(v_cnt_q) >> 4) * COLS + (32'(h_cnt_q) >> 3));
    vrow_d   = v_cnt_q[3:0];
    char_d   = char_mem[cell_0];
  end

  // Read-first: a write to the cell being scanned lands after this read
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < CELLS)) begin
      char_mem[wr_addr[IW-1:0]] <= wr_data;
    end
  end

  assign font_addr = {char_q[7:0], vrow_q};

`ifdef VGA_CURSOR_EN
  logic [5:0] frame_cnt_q, frame_cnt_d;
  logic       cur1_d, cur1_q, cur2_q;

  // Counter holds the index of the frame being scanned; bumps as stage 0 wraps
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if ((h_cnt_q == HMax) && (v_cnt_q == VMax)) begin
      frame_cnt_d = frame_cnt_q + 6'd1;
    end
    cur1_d = !frame_cnt_q[5] && s1_d.act && (h_cnt_q[10:3] == cursor_col) &&
             ({1'b0, v_cnt_q[10:4]} == cursor_row) && (v_cnt_q[3:0] >= 4'd14);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      cur1_q      <= 1'b0;
      cur2_q      <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      cur1_q      <= cur1_d;
      cur2_q      <= cur1_q;
    end
  end
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_col, cursor_row};
`endif

  // Stage 2: glyph bit select and colour/sync formation
  always_comb begin
    pix_bit = font_data[3'd7 - s2_q.hlo];
`ifdef VGA_CURSOR_EN
    if (cur2_q) pix_bit = 1'b1;
`endif
    rgb_d   = s2_q.act ? (pix_bit ? attr_q[2:0] : attr_q[5:3]) : 3'b000;
    hsync_d = s2_q.hs ? HS_POL : ~HS_POL;
    vsync_d = s2_q.vs ? VS_POL : ~VS_POL;
    de_d    = s2_q.act;
    fs_d    = s2_q.fs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      char_q  <= '0;
      vrow_q  <= '0;
      attr_q  <= '0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      rgb_q   <= 3'b000;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s1_q;
      char_q  <= char_d;
      vrow_q  <= vrow_d;
      attr_q  <= char_q[13:8];
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      rgb_q   <= rgb_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign vga_r       = rgb_q[2];
  assign vga_g       = rgb_q[1];
  assign vga_b       = rgb_q[0];

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Bench for vga_text_ctrl on a reduced raster; pixel-exact reference model of the text display.
// Build with VGA_CURSOR_EN defined to also exercise the blinking cursor.
module tb_vga_text_ctrl;

  localparam int HA = 32, HFP = 2, HSW = 2, HBP = 2;
  localparam int VA = 32, VFP = 1, VSW = 2, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int COLS = HA / 8;
  localparam int ROWS = VA / 16;
  localparam int CELLS = COLS * ROWS;
  localparam int AW = 12;
  localparam int BOUND = 2 * FRAME + 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [13:0]   wr_data = '0;
  logic [11:0]   font_addr;
  logic [7:0]    font_data = '0;
  logic [7:0]    cursor_col = 8'd1;
  logic [7:0]    cursor_row = 8'd1;
  logic          hsync, vsync, de, vga_r, vga_g, vga_b, frame_start;
  logic [6:0]    obs;

  logic [7:0]  font_rom [4096];
  logic [13:0] shadow [CELLS];
  int cyc;
  int nvec = 0;
  int nerr = 0;

  vga_text_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLS(COLS), .ROWS(ROWS), .AW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .font_addr(font_addr), .font_data(font_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row),
    .hsync(hsync), .vsync(vsync), .de(de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Font ROM: one cycle of read latency
  always @(posedge clk) font_data <= font_rom[font_addr];

  // Clock edges since reset release; output pixel index is cyc-3
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  assign obs = {hsync, vsync, de, frame_start, vga_r, vga_g, vga_b};

  // Expected {hsync, vsync, de, frame_start, rgb} of output pixel index p
  function automatic logic [6:0] exp_out(input int p);
    int x, y;
    logic [13:0] c;
    logic [7:0] fb;
    logic [3:0] yr;
    logic b, de_e, hs_e, vs_e, fs_e;
    logic [2:0] rgb;
    if (p < 0) return 7'b1100000;
    x = p % HT;
    y = (p / HT) % VT;
    de_e = (x < HA) && (y < VA);
    hs_e = !((x >= HA + HFP) && (x < HA + HFP + HSW));
    vs_e = !((y >= VA + VFP) && (y < VA + VFP + VSW));
    fs_e = (x == 0) && (y == 0);
    rgb = 3'b000;
    if (de_e) begin
      c = shadow[(y / 16) * COLS + x / 8];
      yr = 4'(y % 16);
      fb = font_rom[{c[7:0], yr}];
      b = fb[7 - (x % 8)];
`ifdef VGA_CURSOR_EN
      if (((p / FRAME) % 64 < 32) && (x / 8 == int'(cursor_col)) &&
          (y / 16 == int'(cursor_row)) && (y % 16 >= 14)) b = 1'b1;
`endif
      rgb = b ? c[10:8] : c[13:11];
    end
    return {hs_e, vs_e, de_e, fs_e, rgb};
  endfunction

  function automatic bit is_active(input int q);
    return (q >= 0) && (q % HT < HA) && ((q / HT) % VT < VA);
  endfunction

  function automatic logic [11:0] exp_faddr(input int q);
    int x, y;
    logic [13:0] c;
    x = q % HT;
    y = (q / HT) % VT;
    c = shadow[(y / 16) * COLS + x / 8];
    return {c[7:0], 4'(y % 16)};
  endfunction

  task automatic wait_phase(input int ph, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      if (cyc % FRAME == ph) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Called on a falling edge; the write is taken by the next rising edge
  task automatic wr(input int a, input logic [13:0] d);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (a < CELLS) shadow[a] = d;
  endtask

  task automatic wait_blank(input string name);
    bit ok;
    wait_phase(3 + (VA + 1) * HT, ok);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s_blank_wait: got timeout, expected blank line", name);
    end
  endtask

  task automatic test_frame(input string name);
    bit ok;
    int p, q;
    logic [6:0] e;
    logic [11:0] fa;
    wait_phase(3, ok);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s_sync: got timeout, expected frame start", name);
      return;
    end
    for (int i = 0; i < FRAME; i++) begin
      p = cyc - 3;
      e = exp_out(p);
      nvec++;
      if (obs !== e) begin
        nerr++;
        $display("FAIL %s_pix(%0d,%0d): got %b expected %b", name, p % HT, (p / HT) % VT, obs, e);
      end
      q = cyc - 1;
      if (is_active(q)) begin
        fa = exp_faddr(q);
        nvec++;
        if (font_addr !== fa) begin
          nerr++;
          $display("FAIL %s_font_addr(%0d,%0d): got %h expected %h", name, q % HT,
                   (q / HT) % VT, font_addr, fa);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    nvec++;
    if (obs !== 7'b1100000) begin
      nerr++;
      $display("FAIL reset_out: got %b expected %b", obs, 7'b1100000);
    end
    nvec++;
    if (font_addr !== 12'h000) begin
      nerr++;
      $display("FAIL reset_font_addr: got %h expected 000", font_addr);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      nvec++;
      if (obs[6:3] !== ((k == 3) ? 4'b1111 : 4'b1100)) begin
        nerr++;
        $display("FAIL reset_release_cyc%0d: got %b expected %b", k, obs[6:3],
                 (k == 3) ? 4'b1111 : 4'b1100);
      end
    end
  endtask

  task automatic test_sync();
    bit ok;
    int hs_low = 0, vs_low = 0, de_hi = 0, fs_cnt = 0;
    logic [6:0] e;
    wait_phase(3, ok);
    for (int i = 0; i < FRAME; i++) begin
      e = exp_out(cyc - 3);
      nvec++;
      if (obs[6:3] !== e[6:3]) begin
        nerr++;
        $display("FAIL sync_ctl(%0d): got %b expected %b", cyc - 3, obs[6:3], e[6:3]);
      end
      hs_low += int'(!hsync);
      vs_low += int'(!vsync);
      de_hi  += int'(de);
      fs_cnt += int'(frame_start);
      @(negedge clk);
    end
    nvec++;
    if (hs_low != HSW * VT) begin
      nerr++;
      $display("FAIL sync_hs_count: got %0d expected %0d", hs_low, HSW * VT);
    end
    nvec++;
    if (vs_low != VSW * HT) begin
      nerr++;
      $display("FAIL sync_vs_count: got %0d expected %0d", vs_low, VSW * HT);
    end
    nvec++;
    if (de_hi != HA * VA) begin
      nerr++;
      $display("FAIL sync_de_count: got %0d expected %0d", de_hi, HA * VA);
    end
    nvec++;
    if (fs_cnt != 1) begin
      nerr++;
      $display("FAIL sync_fs_count: got %0d expected 1", fs_cnt);
    end
  endtask

  task automatic test_example();
    bit ok;
    wait_blank("example");
    wr(0, {3'b001, 3'b110, 8'h41});
    for (int c = 1; c < CELLS; c++) wr(c, 14'($urandom));
    wait_phase(1, ok);
    nvec++;
    if (!ok || font_addr !== 12'h410) begin
      nerr++;
      $display("FAIL example_font_addr: got %h expected 410", font_addr);
    end
    repeat (2) @(negedge clk);
    nvec++;
    if (obs[3:0] !== 4'b1110) begin
      nerr++;
      $display("FAIL example_pix0: got fs+rgb %b expected 1110", obs[3:0]);
    end
    @(negedge clk);
    nvec++;
    if (obs[2:0] !== 3'b001) begin
      nerr++;
      $display("FAIL example_pix1: got rgb %b expected 001", obs[2:0]);
    end
    test_frame("example");
  endtask

  task automatic test_oob();
    wait_blank("oob");
    wr(2400, 14'($urandom));
    wr(CELLS, 14'($urandom));
    for (int i = 0; i < 4; i++) wr(CELLS + int'($urandom_range(0, 4095 - CELLS)), 14'($urandom));
    test_frame("oob");
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      wait_blank("random");
      for (int i = 0; i < 6; i++) wr(int'($urandom_range(0, CELLS - 1)), 14'($urandom));
      test_frame("random");
    end
  endtask

  task automatic test_same_cycle();
    bit ok;
    int s = 16 * HT + 8;
    logic [13:0] old, nw;
    logic [7:0] fb;
    logic [2:0] rgb_e;
    old = shadow[5];
    nw = 14'($urandom);
    nw[7:0] = old[7:0] + 8'd1;
    wait_phase(s, ok);
    wr_en = 1'b1;
    wr_addr = AW'(5);
    wr_data = nw;
    @(negedge clk);
    wr_en = 1'b0;
    nvec++;
    if (!ok || font_addr !== {old[7:0], 4'h0}) begin
      nerr++;
      $display("FAIL same_cycle_old_addr: got %h expected %h", font_addr, {old[7:0], 4'h0});
    end
    @(negedge clk);
    nvec++;
    if (font_addr !== {nw[7:0], 4'h0}) begin
      nerr++;
      $display("FAIL same_cycle_new_addr: got %h expected %h", font_addr, {nw[7:0], 4'h0});
    end
    @(negedge clk);
    fb = font_rom[{old[7:0], 4'h0}];
    rgb_e = fb[7] ? old[10:8] : old[13:11];
    nvec++;
    if (obs[2:0] !== rgb_e) begin
      nerr++;
      $display("FAIL same_cycle_old_pix: got %b expected %b", obs[2:0], rgb_e);
    end
    shadow[5] = nw;
    wait_phase(s + 1, ok);
    nvec++;
    if (!ok || font_addr !== {nw[7:0], 4'h0}) begin
      nerr++;
      $display("FAIL same_cycle_next_frame: got %h expected %h", font_addr, {nw[7:0], 4'h0});
    end
    test_frame("same_cycle");
  endtask

  task automatic test_midreset();
    bit ok;
    logic [6:0] e;
    wait_phase(20 * HT + 20, ok);
    rst_n = 1'b0;
    #1;
    nvec++;
    if (!ok || obs !== 7'b1100000 || font_addr !== 12'h000) begin
      nerr++;
      $display("FAIL midreset_async: got %b/%h expected 1100000/000", obs, font_addr);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      nvec++;
      if (obs !== 7'b1100000) begin
        nerr++;
        $display("FAIL midreset_hold%0d: got %b expected 1100000", k, obs);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      e = exp_out(k - 3);
      nvec++;
      if (obs !== e) begin
        nerr++;
        $display("FAIL midreset_release_cyc%0d: got %b expected %b", k, obs, e);
      end
    end
    test_frame("post_reset");
  endtask

  task automatic test_cursor();
`ifdef VGA_CURSOR_EN
    for (int i = 0; i < 34 * FRAME; i++) begin
      if (cyc >= 31 * FRAME) break;
      @(negedge clk);
    end
    nvec++;
    if (cyc < 31 * FRAME) begin
      nerr++;
      $display("FAIL cursor_wait: got cyc %0d expected >= %0d", cyc, 31 * FRAME);
    end
    test_frame("cursor_f31");
    test_frame("cursor_f32");
`else
    cursor_col = 8'd2;
    cursor_row = 8'd0;
    test_frame("cursor_ignored");
`endif
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) font_rom[i] = 8'($urandom);
    font_rom[12'h410] = 8'h80;
    test_reset();
    test_sync();
    test_example();
    test_oob();
    test_random();
    test_same_cycle();
    test_midreset();
    test_cursor();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
